fb_write_sched: RTL
===================

# fb_write_sched

Write-port scheduler for the NES frame buffer BRAM (256×240, 6-bit palette index).
- Owns the single write port and sequences three sources: power-up background/logo fill, the live NES pixel stream, and an on-screen-display (OSD) writer.
- Sits in the NES clock domain, between the PPU outputs and port A of the frame buffer.
- The HDMI side reads port B independently and is unaffected.

## Interface
Parameters:
- FB_W, 256: frame width in pixels; x field is 8 bits.
- FB_H, 240: frame height in lines; y field is 8 bits.
- BG_COLOR, 13: palette index for background fill.
- LOGO_COLOR, 4: palette index for logo pixels.
- LOGO_X0, 96 / LOGO_X1, 160: inclusive logo column window.
- LOGO_Y0, 212 / LOGO_Y1, 224: inclusive logo row window.

Ports:
- clk  in  1  NES clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- color  in  6  NES pixel palette index.
- cycle  in  9  PPU dot counter.
- scanline  in  9  PPU scanline.
- osd_valid  in  1  OSD write request.
- osd_addr  in  16  OSD target address, {y[7:0], x[7:0]}.
- osd_data  in  6  OSD palette index.
- osd_ready  out  1  OSD request accepted this cycle; combinational.
- logo_row  out  4  logo ROM row; combinational from the fill counter.
- logo_col  out  7  logo ROM column; combinational from the fill counter.
- logo_bit  in  1  logo ROM data; valid one cycle after row/col.
- fb_we  out  1  frame buffer write enable; registered.
- fb_addr  out  16  frame buffer address {y, x}; registered.
- fb_wdata  out  6  frame buffer write data; registered.
- init_done  out  1  high once the fill is complete; registered.

## Operation
- States: INIT (fill counter running), DRAIN (one cycle; flushes the last fill write), RUN. Reset → INIT with counter = 0.
- INIT, counter k = {y, x}, 0..61439:
  - In the logo window: logo_row = y − LOGO_Y0, logo_col = x − LOGO_X0. Outside it, both are 0.
  - A stage-1 register holds k, the in-window flag, and valid.
  - Next cycle, stage 1 writes address k with data (in_window & logo_bit) ? LOGO_COLOR : BG_COLOR.
  - When k = 61439 is issued, go to DRAIN, then to RUN.
- NES event:
  - Fires when (scanline, cycle) ≠ registered (r_scanline, r_cycle) AND scanline < 240 AND cycle[8] = 0.
  - r_scanline/r_cycle update every cycle in every state; reset value 9'h1FF each.
  - In RUN, an event writes {scanline[7:0], cycle[7:0]} ← color.
  - In INIT/DRAIN, events are dropped.
- OSD:
  - osd_ready = (state == RUN) & ~nes_event.
  - A transfer happens when osd_valid & osd_ready; it writes osd_addr ← osd_data.
  - The requester holds addr/data while valid & ~ready.
- Priority in RUN: NES > OSD. At most one write per cycle.
- Cycles with no source active: fb_we = 0; fb_addr/fb_wdata hold their last value.
- Arithmetic: counter is 16 bits. Window compares are unsigned on 8-bit x/y. Logo offsets are truncated to 4/7 bits.

## Timing
- Reset values: fb_we 0, fb_addr 0, fb_wdata 0, init_done 0, osd_ready 0, logo_row/logo_col 0.
- Cycle 0 is the first cycle with reset low.
  - Fill address k is issued in cycle k.
  - The write for address k is visible on fb_* in cycle k+2. First fill write: cycle 2, addr 0. Last: cycle 61441, addr 0xEFFF.
  - DRAIN is cycle 61440.
  - RUN and init_done = 1 start at cycle 61441. osd_ready can first be 1 in cycle 61441.
- NES/OSD latency: a request in cycle t is visible on fb_* in cycle t+1.
  - No collision with the final fill write: the DRAIN-cycle write is visible in 61441, and a RUN request in 61441 lands in 61442.
- Reset mid-operation, any state:
  - Next cycle shows reset values.
  - Stage-1 valid is cleared; an in-flight fill write is discarded.
  - Fill restarts at address 0; init_done drops.
  - An OSD request pending across reset is not accepted until RUN.
- Held PPU inputs generate no repeat writes.
- The first RUN cycle generates an event only if the inputs differ from the previous cycle's registered values.

## Test plan
- Reset 1 cycle, logo ROM model returns 1 for (row 0, col 0) only.
  - Exactly 61440 fb_we pulses, cycles 2..61441, addresses 0..0xEFFF in order.
  - Addr 0xD460 (y212, x96) data 4. All others 13.
  - init_done rises in cycle 61441.
- In RUN, drive scanline 10, cycle 20, color 0x21, then hold.
  - Next cycle: fb_we = 1, fb_addr = 0x0A14, fb_wdata = 0x21.
  - Following cycles: fb_we = 0.
- Drive scanline 240 / cycle 0, then scanline 5 / cycle 256, each changing every cycle → fb_we stays 0.
- In RUN, osd_valid with addr 0x0102, data 0x30, in the same cycle as a NES event at (3,4).
  - That cycle: osd_ready = 0.
  - Next cycle: write 0x0304 ← color; osd_ready = 1.
  - Cycle after: write 0x0102 ← 0x30.
- osd_valid held high from cycle 0 → osd_ready = 0 through cycle 61440; accepted in cycle 61441.
  - NES events toggled during INIT produce no writes outside the fill sequence.
- Assert reset when the fill counter = 1000.
  - fb_we = 0 and init_done = 0 the next cycle.
  - After release, the fill restarts: addr 0 visible 2 cycles later; a full 61440-write sequence completes.

Source files
------------

// File: rtl/fb_write_sched.sv
// fb_write_sched
// Write-port scheduler for the NES frame buffer BRAM (256x240, 6-bit palette
// index). After reset it paints the whole frame with the background colour and
// overlays the logo. Once that is done it forwards live PPU pixels and
// on-screen-display writes to port A of the frame buffer. PPU pixels always win
// over OSD writes.
//
// Ports
//   clk        NES clock, the only clock of this block
//   reset      synchronous, active-high reset
//   color      PPU pixel palette index
//   cycle      PPU dot counter
//   scanline   PPU scanline
//   osd_valid  OSD write request; addr/data are held until accepted
//   osd_addr   OSD target address {y, x}
//   osd_data   OSD palette index
//   osd_ready  OSD request accepted this cycle (combinational)
//   logo_row   logo ROM row, combinational from the fill counter
//   logo_col   logo ROM column, combinational from the fill counter
//   logo_bit   logo ROM data, one cycle after logo_row/logo_col
//   fb_we      frame buffer write enable (registered)
//   fb_addr    frame buffer address {y, x} (registered)
//   fb_wdata   frame buffer write data (registered)
//   init_done  high once the power-up fill is complete (registered)

module fb_write_sched #(
    parameter int FB_W       = 256,
    parameter int FB_H       = 240,
    parameter int BG_COLOR   = 13,
    parameter int LOGO_COLOR = 4,
    parameter int LOGO_X0    = 96,
    parameter int LOGO_X1    = 160,
    parameter int LOGO_Y0    = 212,
    parameter int LOGO_Y1    = 224
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  color,
    input  logic [8:0]  cycle,
    input  logic [8:0]  scanline,
    input  logic        osd_valid,
    input  logic [15:0] osd_addr,
    input  logic [5:0]  osd_data,
    output logic        osd_ready,
    output logic [3:0]  logo_row,
    output logic [6:0]  logo_col,
    input  logic        logo_bit,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [5:0]  fb_wdata,
    output logic        init_done
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [15:0] FILL_LAST = 16'(FB_W * FB_H - 1);
    localparam logic [8:0]  VIS_LINES = 9'(FB_H);
    localparam logic [7:0]  WIN_X0    = 8'(LOGO_X0);
    localparam logic [7:0]  WIN_X1    = 8'(LOGO_X1);
    localparam logic [7:0]  WIN_Y0    = 8'(LOGO_Y0);
    localparam logic [7:0]  WIN_Y1    = 8'(LOGO_Y1);
    localparam logic [5:0]  BG_IDX    = 6'(BG_COLOR);
    localparam logic [5:0]  LOGO_IDX  = 6'(LOGO_COLOR);

    logic [1:0]  state;
    logic [15:0] fill_cnt;
    logic [7:0]  fill_x;
    logic [7:0]  fill_y;
    logic [7:0]  row_off;
    logic [7:0]  col_off;
    logic        in_window;

    logic        s1_valid;
    logic [15:0] s1_addr;
    logic        s1_in_window;

    logic [8:0]  r_scanline;
    logic [8:0]  r_cycle;
    logic        nes_event;
    logic        run;
    logic        osd_take;

    // The frame is exactly 256 wide, so the linear fill counter already is
    // the {y, x} address.
    assign fill_x  = fill_cnt[7:0];
    assign fill_y  = fill_cnt[15:8];
    assign row_off = fill_y - WIN_Y0;
    assign col_off = fill_x - WIN_X0;

    // The window flag is qualified with INIT so the ROM address stays at 0
    // once the fill is over.
    assign in_window = (state == ST_INIT) &&
                       (fill_x >= WIN_X0) && (fill_x <= WIN_X1) &&
                       (fill_y >= WIN_Y0) && (fill_y <= WIN_Y1);

    assign logo_row = in_window ? row_off[3:0] : 4'd0;
    assign logo_col = in_window ? col_off[6:0] : 7'd0;

    // A pixel event is a change of PPU position inside the visible area.
    // Holding the inputs steady produces no repeat writes.
    assign nes_event = ({scanline, cycle} != {r_scanline, r_cycle}) &&
                       (scanline < VIS_LINES) && !cycle[8];

    assign run = (state == ST_RUN);

    // Reset also gates ready. A request held across reset then cannot slip
    // through in the reset cycle itself.
    assign osd_ready = !reset && run && !nes_event;
    assign osd_take  = osd_valid && osd_ready;

    // Sequencer: INIT walks the fill counter over every address once. DRAIN
    // gives stage 1 one cycle to flush the final fill pixel. RUN serves the
    // live sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            fill_cnt  <= 16'd0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= ST_DRAIN;
                    end else begin
                        fill_cnt <= fill_cnt + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Stage 1 waits one cycle with the fill address, so the write lines up
    // with the logo ROM data for that address.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_addr      <= 16'd0;
            s1_in_window <= 1'b0;
        end else begin
            s1_valid     <= (state == ST_INIT);
            s1_addr      <= fill_cnt;
            s1_in_window <= in_window;
        end
    end

    // Previous PPU position, updated every cycle in every state, so the
    // first RUN cycle compares against real history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scanline <= 9'h1FF;
            r_cycle    <= 9'h1FF;
        end else begin
            r_scanline <= scanline;
            r_cycle    <= cycle;
        end
    end

    // The single write port. Fill writes only exist in INIT/DRAIN and live
    // writes only in RUN, so the two never compete.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_we    <= 1'b0;
            fb_addr  <= 16'd0;
            fb_wdata <= 6'd0;
        end else if (s1_valid) begin
            fb_we    <= 1'b1;
            fb_addr  <= s1_addr;
            fb_wdata <= (s1_in_window && logo_bit) ? LOGO_IDX : BG_IDX;
        end else if (run && nes_event) begin
            fb_we    <= 1'b1;
            fb_addr  <= {scanline[7:0], cycle[7:0]};
            fb_wdata <= color;
        end else if (osd_take) begin
            fb_we    <= 1'b1;
            fb_addr  <= osd_addr;
            fb_wdata <= osd_data;
        end else begin
            fb_we    <= 1'b0;
        end
    end

endmodule
